// File: rtl/rv32v_types_pkg.sv
// Shared RV32V lane types: operand sign kind, divider FSM states,
// divider result-select constants and the iteration-count helper.
package rv32v_types_pkg;

   typedef enum logic {
      SIGN_UNSIGNED = 1'b0,
      SIGN_SIGNED   = 1'b1
   } sign_type_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } div_state_t;

   localparam logic DIV_QUOTIENT  = 1'b0;
   localparam logic DIV_REMAINDER = 1'b1;

   // One restoring iteration retires bits_per_cycle quotient bits.
   function automatic int div_iters(input int width, input int bits_per_cycle);
      return width / bits_per_cycle;
   endfunction

endpackage

// File: rtl/rv32v_div_step.sv
// Combinational restoring divide step: retires BITS_PER_CYCLE quotient bits
// by shifting the dividend/quotient register into the partial remainder.
module rv32v_div_step #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dsr,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   always_comb begin : step
      logic [WIDTH:0]   w_trial;
      logic [WIDTH-1:0] w_rem;
      logic [WIDTH-1:0] w_quo;
      w_rem   = i_rem;
      w_quo   = i_quo;
      w_trial = '0;
      // The partial remainder stays below the divisor, so the trial fits WIDTH+1 bits.
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         w_trial = {w_rem, w_quo[WIDTH-1]};
         w_quo   = {w_quo[WIDTH-2:0], 1'b0};
         if (w_trial >= {1'b0, i_dsr}) begin
            w_trial  = w_trial - {1'b0, i_dsr};
            w_quo[0] = 1'b1;
         end
         w_rem = w_trial[WIDTH-1:0];
      end
      o_rem = w_rem;
      o_quo = w_quo;
   end

endmodule

// File: rtl/rv32v_divide_unit_param.sv
// Iterative RV32V lane divider (quotient/remainder, signed/unsigned, tagged).
// Define RV32V_DIV_ZERO_EXCEPTION_EN to flag divide-by-zero on exception_du.
module rv32v_divide_unit_param
   import rv32v_types_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int TAG_W          = 5
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [WIDTH-1:0] vs2_data,
   input  logic [WIDTH-1:0] vs1_data,
   input  logic             start_div,
   input  logic             div_type,
   input  logic             is_signed_div,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             kill,
   output logic [WIDTH-1:0] wdata_du,
   output logic [TAG_W-1:0] tag_out,
   output logic             busy_du,
   output logic             done_du,
   output logic             exception_du
);

   localparam int N_ITER = div_iters(WIDTH, BITS_PER_CYCLE);
   localparam int CNT_W  = $clog2(N_ITER) + 1;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dsr;
   logic             r_q_neg;
   logic             r_r_neg;
   logic             r_type;
   logic [TAG_W-1:0] r_tag;
   logic [WIDTH-1:0] r_wdata;
   logic [TAG_W-1:0] r_tag_out;
   logic             r_done;
`ifdef RV32V_DIV_ZERO_EXCEPTION_EN
   logic             r_exc;
`endif

   sign_type_t       w_sign;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic             w_div_zero;
   logic             w_ovf;
   logic [WIDTH-1:0] w_special;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;
   logic [WIDTH-1:0] w_result;

   assign w_sign     = sign_type_t'(is_signed_div);
   assign w_a_neg    = (w_sign == SIGN_SIGNED) && vs2_data[WIDTH-1];
   assign w_b_neg    = (w_sign == SIGN_SIGNED) && vs1_data[WIDTH-1];
   assign w_abs_a    = w_a_neg ? -vs2_data : vs2_data;
   assign w_abs_b    = w_b_neg ? -vs1_data : vs1_data;
   assign w_div_zero = (vs1_data == '0);
   assign w_ovf      = (w_sign == SIGN_SIGNED) && (vs2_data == MIN_VAL) && (vs1_data == '1);

   // Divide-by-zero outranks overflow; both finish without iterating.
   always_comb begin
      w_special = '0;
      if (w_div_zero)
         w_special = (div_type == DIV_REMAINDER) ? vs2_data : '1;
      else
         w_special = (div_type == DIV_REMAINDER) ? '0 : vs2_data;
   end

   rv32v_div_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_dsr (r_dsr),
      .o_rem (w_rem_nxt),
      .o_quo (w_quo_nxt)
   );

   assign w_q_fix  = r_q_neg ? -w_quo_nxt : w_quo_nxt;
   assign w_r_fix  = r_r_neg ? -w_rem_nxt : w_rem_nxt;
   assign w_result = (r_type == DIV_REMAINDER) ? w_r_fix : w_q_fix;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_dsr     <= '0;
         r_q_neg   <= 1'b0;
         r_r_neg   <= 1'b0;
         r_type    <= 1'b0;
         r_tag     <= '0;
         r_wdata   <= '0;
         r_tag_out <= '0;
         r_done    <= 1'b0;
`ifdef RV32V_DIV_ZERO_EXCEPTION_EN
         r_exc     <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef RV32V_DIV_ZERO_EXCEPTION_EN
         r_exc  <= 1'b0;
`endif
         if (kill) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               // FIN is the done cycle; it accepts a new request like IDLE.
               IDLE, FIN: begin
                  if (start_div) begin
                     if (w_div_zero || w_ovf) begin
                        r_wdata   <= w_special;
                        r_tag_out <= tag_in;
                        r_done    <= 1'b1;
`ifdef RV32V_DIV_ZERO_EXCEPTION_EN
                        r_exc     <= w_div_zero;
`endif
                        r_state   <= FIN;
                     end else begin
                        r_rem   <= '0;
                        r_quo   <= w_abs_a;
                        r_dsr   <= w_abs_b;
                        r_q_neg <= w_a_neg ^ w_b_neg;
                        r_r_neg <= w_a_neg;
                        r_type  <= div_type;
                        r_tag   <= tag_in;
                        r_cnt   <= CNT_W'(N_ITER - 1);
                        r_state <= CALC;
                     end
                  end else begin
                     r_state <= IDLE;
                  end
               end
               CALC: begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  if (r_cnt == '0) begin
                     r_wdata   <= w_result;
                     r_tag_out <= r_tag;
                     r_done    <= 1'b1;
                     r_state   <= FIN;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign wdata_du = r_wdata;
   assign tag_out  = r_tag_out;
   assign done_du  = r_done;
   assign busy_du  = (r_state == CALC);
`ifdef RV32V_DIV_ZERO_EXCEPTION_EN
   assign exception_du = r_exc;
`else
   assign exception_du = 1'b0;
`endif

endmodule
